// File: rtl/imem_fetch_arbiter.sv
// imem_fetch_arbiter: shares one byte-addressed instruction memory between CPU fetch reads and loader byte writes.
// Optional range checking is enabled with the IMEM_BOUNDS_CHECK_EN macro.
module imem_fetch_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int MEM_BYTES  = 501,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [31:0]       f_rdata,
  output logic              f_err,
  input  logic              l_req,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [7:0]        l_wdata,
  output logic              l_gnt,
  output logic [ADDR_W-1:0] m_addr,
  output logic              m_re,
  output logic              m_we,
  output logic [7:0]        m_wdata,
  input  logic [31:0]       m_rdata
);

  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

`ifdef IMEM_BOUNDS_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] F_LAST = ADDR_W'(MEM_BYTES - 4);
  localparam logic [ADDR_W-1:0] L_END  = ADDR_W'(MEM_BYTES);

  typedef enum logic [1:0] {
    IDLE,
    WR,
    RD_ISSUE,
    RD_WAIT
  } state_e;

  state_e state_q, state_d;

  logic [CW-1:0] starve_q, starve_d;
  logic          oob_q, oob_d;

  logic              f_gnt_q, f_gnt_d;
  logic              f_rvalid_q, f_rvalid_d;
  logic [31:0]       f_rdata_q, f_rdata_d;
  logic              f_err_q, f_err_d;
  logic              l_gnt_q, l_gnt_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic              m_re_q, m_re_d;
  logic              m_we_q, m_we_d;
  logic [7:0]        m_wdata_q, m_wdata_d;

  logic idle;
  logic pick_wr;
  logic pick_rd;
  logic f_oob;
  logic l_oob;

  assign idle    = (state_q == IDLE);
  assign pick_wr = idle && l_req
                && (!f_req || (starve_q < SMAX));
  assign pick_rd = idle && f_req && !pick_wr;

  assign f_oob = CHK_EN && (f_addr > F_LAST);
  assign l_oob = CHK_EN && (l_addr >= L_END);

  // state, starvation count and all registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      starve_q   <= '0;
      oob_q      <= 1'b0;
      f_gnt_q    <= 1'b0;
      f_rvalid_q <= 1'b0;
      f_rdata_q  <= '0;
      f_err_q    <= 1'b0;
      l_gnt_q    <= 1'b0;
      m_addr_q   <= '0;
      m_re_q     <= 1'b0;
      m_we_q     <= 1'b0;
      m_wdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      oob_q      <= oob_d;
      f_gnt_q    <= f_gnt_d;
      f_rvalid_q <= f_rvalid_d;
      f_rdata_q  <= f_rdata_d;
      f_err_q    <= f_err_d;
      l_gnt_q    <= l_gnt_d;
      m_addr_q   <= m_addr_d;
      m_re_q     <= m_re_d;
      m_we_q     <= m_we_d;
      m_wdata_q  <= m_wdata_d;
    end
  end

  // next-state: one arbitration per visit to IDLE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (pick_wr) begin
          state_d = WR;
        end else if (pick_rd) begin
          state_d = RD_ISSUE;
        end
      end
      WR:       state_d = IDLE;
      RD_ISSUE: state_d = RD_WAIT;
      RD_WAIT:  state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // fetch loses to loader only while the count is below the cap
  always_comb begin
    starve_d = starve_q;
    if (idle) begin
      if (!f_req) begin
        starve_d = '0;
      end else if (pick_wr) begin
        if (starve_q < SMAX) begin
          starve_d = starve_q + CW'(1);
        end
      end else begin
        starve_d = '0;
      end
    end
  end

  // next values of the registered outputs
  always_comb begin
    f_gnt_d    = 1'b0;
    f_rvalid_d = 1'b0;
    f_rdata_d  = f_rdata_q;
    f_err_d    = 1'b0;
    l_gnt_d    = 1'b0;
    m_addr_d   = '0;
    m_re_d     = 1'b0;
    m_we_d     = 1'b0;
    m_wdata_d  = '0;
    oob_d      = oob_q;
    unique case (1'b1)
      pick_wr: begin
        l_gnt_d   = 1'b1;
        m_addr_d  = l_addr;
        m_wdata_d = l_wdata;
        m_we_d    = !l_oob;
      end
      pick_rd: begin
        f_gnt_d  = 1'b1;
        m_addr_d = f_addr;
        m_re_d   = !f_oob;
        oob_d    = f_oob;
      end
      default: ;
    endcase
    if (state_q == RD_WAIT) begin
      f_rvalid_d = 1'b1;
      f_err_d    = oob_q;
      f_rdata_d  = oob_q ? 32'h0000_0000 : m_rdata;
    end
  end

  assign f_gnt    = f_gnt_q;
  assign f_rvalid = f_rvalid_q;
  assign f_rdata  = f_rdata_q;
  assign f_err    = f_err_q;
  assign l_gnt    = l_gnt_q;
  assign m_addr   = m_addr_q;
  assign m_re     = m_re_q;
  assign m_we     = m_we_q;
  assign m_wdata  = m_wdata_q;

endmodule
